// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
//   Shared I2C definitions for i2c_target (state encodings also used by
//   i2c_master), bus bit constants and field widths.
//   Optional build macro: I2C_GLITCH_FILTER_EN (used by i2c_line_sync/top).
// ----------------------------------------------------------------------------
package i2c_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned ADDR_W    = 7;
   localparam int unsigned BIT_CNT_W = 3;

   localparam logic I2C_ACK     = 1'b0;
   localparam logic I2C_NACK    = 1'b1;
   localparam logic I2C_RW_READ = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } i2c_state_e;

   // Open-drain: putting a 0 on the bus means pulling SDA low.
   function automatic logic bit_to_oe(input logic bit_val);
      return (bit_val == 1'b0);
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// ----------------------------------------------------------------------------
// i2c_line_sync
//   Conditions one asynchronous open-drain line: 2-flop synchronizer, optional
//   glitch filter (I2C_GLITCH_FILTER_EN), and rise/fall pulses on the result.
// Ports
//   clk, reset   : system clock, async active-high reset
//   i_line       : raw pad input
//   o_level      : conditioned line level
//   o_rise_c     : 1-cycle pulse, conditioned level went 0->1 (combinational)
//   o_fall_c     : 1-cycle pulse, conditioned level went 1->0 (combinational)
// ----------------------------------------------------------------------------
module i2c_line_sync
`ifdef I2C_GLITCH_FILTER_EN
#(
   parameter int unsigned FILT_LEN = 3
)
`endif
(
   input  logic clk,
   input  logic reset,
   input  logic i_line,
   output logic o_level,
   output logic o_rise_c,
   output logic o_fall_c
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic w_level;

   // Synchronizer; reset to the idle (released, high) bus level.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_line;
         r_sync2 <= r_sync1;
      end
   end

`ifdef I2C_GLITCH_FILTER_EN
   localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             r_filt;

   // Accept a new level only after FILT_LEN consecutive samples of it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt  <= '0;
         r_filt <= 1'b1;
      end else if (r_sync2 == r_filt) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_W'(FILT_LEN - 1)) begin
         r_filt <= r_sync2;
         r_cnt  <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign w_level = r_filt;
`else
   assign w_level = r_sync2;
`endif

   // Previous level for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= w_level;
      end
   end

   assign o_level  = w_level;
   assign o_rise_c = w_level & ~r_prev;
   assign o_fall_c = ~w_level & r_prev;

endmodule

// File: rtl/i2c_target.sv
// ----------------------------------------------------------------------------
// i2c_target
//   I2C target at fixed 7-bit address ADDR. Detects START/STOP, matches the
//   address, ACKs, hands written bytes to the host and serves read bytes.
//   Optional build macro: I2C_GLITCH_FILTER_EN (adds FILT_LEN input filter).
// Ports
//   clk, reset : system clock (>= 10x SCL), async active-high reset
//   scl_in     : SCL pad input          sda_in  : SDA pad input
//   sda_oe     : 1 = pull SDA low
//   rx_data    : last written byte      rx_valid: 1-cycle pulse, rx_data new
//   tx_req     : 1-cycle pulse, host presents next read byte on tx_data
//   tx_data    : read byte, sampled on the SCL fall that starts its MSB
//   busy       : addressed and transaction in progress
//   addr_hit   : 1-cycle pulse on address match
//   rw_bit     : R/W bit of the current transaction (1 = read)
// ----------------------------------------------------------------------------
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDR = 7'h50
`ifdef I2C_GLITCH_FILTER_EN
   ,
   parameter int unsigned FILT_LEN = 3
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic [BYTE_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              tx_req,
   input  logic [BYTE_W-1:0] tx_data,
   output logic              busy,
   output logic              addr_hit,
   output logic              rw_bit
);

   localparam logic [BIT_CNT_W-1:0] BIT_MSB = BIT_CNT_W'(BYTE_W - 1);

   logic w_scl, w_scl_rise, w_scl_fall;
   logic w_sda, w_sda_rise, w_sda_fall;
   logic w_start, w_stop;

   i2c_state_e             r_state,    w_state_nxt;
   logic [BIT_CNT_W-1:0]   r_cnt,      w_cnt_nxt;
   logic [BYTE_W-1:0]      r_shift,    w_shift_nxt;
   logic [BYTE_W-1:0]      r_rx_data,  w_rx_data_nxt;
   logic                   r_sda_oe,   w_sda_oe_nxt;
   logic                   r_rx_valid, w_rx_valid_nxt;
   logic                   r_tx_req,   w_tx_req_nxt;
   logic                   r_busy,     w_busy_nxt;
   logic                   r_addr_hit, w_addr_hit_nxt;
   logic                   r_rw_bit,   w_rw_bit_nxt;
   // Within an ACK state: 0 until the first qualifying SCL edge has been seen.
   logic                   r_phase,    w_phase_nxt;
   logic [BYTE_W-1:0]      w_byte;

   i2c_line_sync
`ifdef I2C_GLITCH_FILTER_EN
      #(.FILT_LEN(FILT_LEN))
`endif
   u_scl_sync (
      .clk      (clk),
      .reset    (reset),
      .i_line   (scl_in),
      .o_level  (w_scl),
      .o_rise_c (w_scl_rise),
      .o_fall_c (w_scl_fall)
   );

   i2c_line_sync
`ifdef I2C_GLITCH_FILTER_EN
      #(.FILT_LEN(FILT_LEN))
`endif
   u_sda_sync (
      .clk      (clk),
      .reset    (reset),
      .i_line   (sda_in),
      .o_level  (w_sda),
      .o_rise_c (w_sda_rise),
      .o_fall_c (w_sda_fall)
   );

   assign w_start = w_sda_fall & w_scl;
   assign w_stop  = w_sda_rise & w_scl;
   assign w_byte  = {r_shift[BYTE_W-2:0], w_sda};

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_rx_data  <= '0;
         r_sda_oe   <= 1'b0;
         r_rx_valid <= 1'b0;
         r_tx_req   <= 1'b0;
         r_busy     <= 1'b0;
         r_addr_hit <= 1'b0;
         r_rw_bit   <= 1'b0;
         r_phase    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_rx_data  <= w_rx_data_nxt;
         r_sda_oe   <= w_sda_oe_nxt;
         r_rx_valid <= w_rx_valid_nxt;
         r_tx_req   <= w_tx_req_nxt;
         r_busy     <= w_busy_nxt;
         r_addr_hit <= w_addr_hit_nxt;
         r_rw_bit   <= w_rw_bit_nxt;
         r_phase    <= w_phase_nxt;
      end
   end

   // Next-state and output logic; START/STOP take priority over every state.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_shift_nxt    = r_shift;
      w_rx_data_nxt  = r_rx_data;
      w_sda_oe_nxt   = r_sda_oe;
      w_rx_valid_nxt = 1'b0;
      w_tx_req_nxt   = 1'b0;
      w_busy_nxt     = r_busy;
      w_addr_hit_nxt = 1'b0;
      w_rw_bit_nxt   = r_rw_bit;
      w_phase_nxt    = r_phase;

      if (w_start) begin
         w_state_nxt  = ST_ADDR;
         w_cnt_nxt    = BIT_MSB;
         w_sda_oe_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
         w_phase_nxt  = 1'b0;
      end else if (w_stop) begin
         w_state_nxt  = ST_IDLE;
         w_sda_oe_nxt = 1'b0;
         w_busy_nxt   = 1'b0;
         w_phase_nxt  = 1'b0;
      end else begin
         unique case (r_state)
            ST_ADDR: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_byte;
                  if (r_cnt != '0) begin
                     w_cnt_nxt = r_cnt - BIT_CNT_W'(1);
                  end else if (w_byte[BYTE_W-1:1] == ADDR &&
                               w_byte[BYTE_W-1:1] != '0) begin
                     w_addr_hit_nxt = 1'b1;
                     w_busy_nxt     = 1'b1;
                     w_rw_bit_nxt   = w_byte[0];
                     w_phase_nxt    = 1'b0;
                     w_state_nxt    = ST_ADDR_ACK;
                  end else begin
                     w_state_nxt = ST_WAIT_STOP;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (w_scl_fall && !r_phase) begin
                  w_sda_oe_nxt = bit_to_oe(I2C_ACK);
                  w_phase_nxt  = 1'b1;
               end else if (w_scl_rise && r_phase && r_rw_bit == I2C_RW_READ) begin
                  w_tx_req_nxt = 1'b1;
               end else if (w_scl_fall && r_phase) begin
                  w_cnt_nxt   = BIT_MSB;
                  w_phase_nxt = 1'b0;
                  if (r_rw_bit == I2C_RW_READ) begin
                     w_shift_nxt  = tx_data;
                     w_sda_oe_nxt = bit_to_oe(tx_data[BYTE_W-1]);
                     w_state_nxt  = ST_RD_DATA;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     w_state_nxt  = ST_WR_DATA;
                  end
               end
            end
            ST_WR_DATA: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_byte;
                  if (r_cnt != '0) begin
                     w_cnt_nxt = r_cnt - BIT_CNT_W'(1);
                  end else begin
                     w_rx_data_nxt  = w_byte;
                     w_rx_valid_nxt = 1'b1;
                     w_phase_nxt    = 1'b0;
                     w_state_nxt    = ST_WR_ACK;
                  end
               end
            end
            ST_WR_ACK: begin
               if (w_scl_fall) begin
                  if (!r_phase) begin
                     w_sda_oe_nxt = bit_to_oe(I2C_ACK);
                     w_phase_nxt  = 1'b1;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     w_cnt_nxt    = BIT_MSB;
                     w_phase_nxt  = 1'b0;
                     w_state_nxt  = ST_WR_DATA;
                  end
               end
            end
            ST_RD_DATA: begin
               // Rotating keeps the next bit to drive at the MSB.
               if (w_scl_fall) begin
                  if (r_cnt == '0) begin
                     w_sda_oe_nxt = 1'b0;
                     w_phase_nxt  = 1'b0;
                     w_state_nxt  = ST_RD_ACK;
                  end else begin
                     w_shift_nxt  = {r_shift[BYTE_W-2:0], r_shift[BYTE_W-1]};
                     w_sda_oe_nxt = bit_to_oe(r_shift[BYTE_W-2]);
                     w_cnt_nxt    = r_cnt - BIT_CNT_W'(1);
                  end
               end
            end
            ST_RD_ACK: begin
               if (w_scl_rise && !r_phase) begin
                  if (w_sda == I2C_NACK) begin
                     w_busy_nxt  = 1'b0;
                     w_state_nxt = ST_WAIT_STOP;
                  end else begin
                     w_tx_req_nxt = 1'b1;
                     w_phase_nxt  = 1'b1;
                  end
               end else if (w_scl_fall && r_phase) begin
                  w_shift_nxt  = tx_data;
                  w_sda_oe_nxt = bit_to_oe(tx_data[BYTE_W-1]);
                  w_cnt_nxt    = BIT_MSB;
                  w_phase_nxt  = 1'b0;
                  w_state_nxt  = ST_RD_DATA;
               end
            end
            ST_IDLE, ST_WAIT_STOP: begin
               w_sda_oe_nxt = 1'b0;
            end
            default: begin
               w_state_nxt  = ST_IDLE;
               w_sda_oe_nxt = 1'b0;
            end
         endcase
      end
   end

   assign sda_oe   = r_sda_oe;
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign tx_req   = r_tx_req;
   assign busy     = r_busy;
   assign addr_hit = r_addr_hit;
   assign rw_bit   = r_rw_bit;

endmodule
